// File: rtl/coproc_sequencer.sv
// Sequencer for the shared 8-bit adder/multiplier datapath: accepts toggle-tag
// requests from the MCU, runs the opcode's step sequence and posts a completion tag.
module coproc_sequencer #(
    parameter logic [7:0] ADD_K = 8'd3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic [1:0] op_in,
    input  logic       tag_in,
    output logic [7:0] result,
    output logic       done_tag,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic [1:0] {IDLE, MUL1, ADD, MUL2} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, prev_tag_q;
    logic [7:0]  x_q, t_q, result_q;
    logic [1:0]  op_q;
    logic        ovf_run_q, ovf_q, done_tag_q, busy_q;

    logic [7:0]  mul_a, mul_b, add_a;
    logic [15:0] prod;
    logic [8:0]  sum;
    logic [7:0]  step_lo;
    logic        step_hi, last;

    // Operand select: idle unit inputs stay at zero; ADD reads x only when it is the first step.
    always_comb begin
        mul_a = 8'd0;
        mul_b = 8'd0;
        add_a = 8'd0;
        case (state_q)
            MUL1: begin
                mul_a = x_q;
                mul_b = x_q;
            end
            ADD:  add_a = (op_q == 2'd1) ? x_q : t_q;
            MUL2: begin
                mul_a = t_q;
                mul_b = t_q;
            end
            default: ;
        endcase
    end

    assign prod = 16'(mul_a) * 16'(mul_b);
    assign sum  = 9'(add_a) + 9'(ADD_K);

    always_comb begin
        step_lo = 8'd0;
        step_hi = 1'b0;
        last    = 1'b0;
        state_d = IDLE;
        case (state_q)
            MUL1: begin
                step_lo = prod[7:0];
                step_hi = |prod[15:8];
                last    = (op_q == 2'd0);
                state_d = last ? IDLE : ADD;
            end
            ADD: begin
                step_lo = sum[7:0];
                step_hi = sum[8];
                last    = (op_q != 2'd3);
                state_d = last ? IDLE : MUL2;
            end
            MUL2: begin
                step_lo = prod[7:0];
                step_hi = |prod[15:8];
                last    = 1'b1;
                state_d = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_tag_q <= 1'b0;
            x_q        <= 8'd0;
            op_q       <= 2'd0;
            t_q        <= 8'd0;
            ovf_run_q  <= 1'b0;
            result_q   <= 8'd0;
            ovf_q      <= 1'b0;
            done_tag_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q <= tag_in;
            sync2_q <= sync1_q;
            if (state_q == IDLE) begin
                // A tag change seen while busy is left pending and picked up here.
                if (sync2_q != prev_tag_q) begin
                    x_q        <= data_in;
                    op_q       <= op_in;
                    prev_tag_q <= sync2_q;
                    busy_q     <= 1'b1;
                    ovf_run_q  <= 1'b0;
                    state_q    <= (op_in == 2'd1) ? ADD : MUL1;
                end
            end else begin
                t_q       <= step_lo;
                ovf_run_q <= ovf_run_q | step_hi;
                state_q   <= state_d;
                if (last) begin
                    result_q   <= step_lo;
                    ovf_q      <= ovf_run_q | step_hi;
                    done_tag_q <= ~done_tag_q;
                    busy_q     <= 1'b0;
                end
            end
        end
    end

    assign result   = result_q;
    assign done_tag = done_tag_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_coproc_sequencer.sv
// Randomized and directed bench for coproc_sequencer against a cycle-count reference model.
module tb_coproc_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [1:0] op_in = 2'd0;
    logic       tag_in = 1'b0;
    logic [7:0] result;
    logic       done_tag, busy, ovf;

    int total = 0;
    int bad = 0;

    coproc_sequencer #(.ADD_K(8'd3)) dut (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .op_in(op_in),
        .tag_in(tag_in), .result(result), .done_tag(done_tag), .busy(busy), .ovf(ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {ovf, result} for a request.
    function automatic logic [8:0] ref_eval(input logic [7:0] x, input logic [1:0] op);
        int  v;
        logic o;
        v = x;
        o = 1'b0;
        if (op != 2'd1) begin v = v * v; o = o | (v > 255); v = v % 256; end
        if (op != 2'd0) begin v = v + 3; o = o | (v > 255); v = v % 256; end
        if (op == 2'd3) begin v = v * v; o = o | (v > 255); v = v % 256; end
        return {o, 8'(v)};
    endfunction

    function automatic int ref_steps(input logic [1:0] op);
        return (op == 2'd3) ? 3 : (op == 2'd2) ? 2 : 1;
    endfunction

    // Reference model: tag seen two edges late, then a countdown of ref_steps edges.
    logic       m_s1, m_s2, m_prev, m_busy, m_done, m_ovf;
    logic [7:0] m_res;
    logic [8:0] m_pend;
    int         m_left;
    int         m_completions = 0;
    int         dut_edges = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_prev <= 1'b0; m_busy <= 1'b0;
            m_done <= 1'b0; m_ovf <= 1'b0; m_res <= 8'd0; m_pend <= 9'd0; m_left <= 0;
        end else begin
            m_s1 <= tag_in;
            m_s2 <= m_s1;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_res  <= m_pend[7:0];
                    m_ovf  <= m_pend[8];
                    m_done <= ~m_done;
                    m_completions <= m_completions + 1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (m_s2 != m_prev) begin
                m_prev <= m_s2;
                m_busy <= 1'b1;
                m_pend <= ref_eval(data_in, op_in);
                m_left <= ref_steps(op_in);
            end
        end
    end

    always @(negedge clock) begin
        chk("busy", int'(busy), int'(m_busy));
        chk("done_tag", int'(done_tag), int'(m_done));
        chk("result", int'(result), int'(m_res));
        chk("ovf", int'(ovf), int'(m_ovf));
    end

    always @(done_tag) if (reset_n) dut_edges++;

    task automatic wait_busy();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy) begin seen = 1'b1; break; end
        end
        chk("busy_rise_timeout", int'(seen), 1);
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done_tag == tag_in && !busy) begin ok = 1'b1; break; end
        end
        chk("done_timeout", int'(ok), 1);
    endtask

    task automatic do_req(input logic [7:0] x, input logic [1:0] op, input int off,
                          input logic lit, input int er, input int eo, input int ecyc);
        int   nb;
        logic ok;
        nb = 0;
        ok = 1'b0;
        @(posedge clock);
        #(off);
        data_in = x;
        op_in   = op;
        tag_in  = ~tag_in;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (busy) nb++;
            if (done_tag == tag_in && !busy) begin ok = 1'b1; break; end
        end
        chk("req_timeout", int'(ok), 1);
        if (lit) begin
            chk("lit_result", int'(result), er);
            chk("lit_ovf", int'(ovf), eo);
            chk("lit_busy_cycles", nb, ecyc);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_done_tag", int'(done_tag), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf), 0);

        // Abort an op-3 run one edge after accept.
        @(posedge clock);
        #3 data_in = 8'd5; op_in = 2'd3; tag_in = 1'b1;
        wait_busy();
        @(posedge clock);
        #1 reset_n = 1'b0; tag_in = 1'b0;
        #1;
        chk("abort_result", int'(result), 0);
        chk("abort_done_tag", int'(done_tag), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ovf", int'(ovf), 0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("post_rst_done_tag", int'(done_tag), 0);
        chk("post_rst_busy", int'(busy), 0);

        do_req(8'd5,   2'd3, 3, 1'b1, 16,  1, 3);
        chk("tag_after_op3", int'(done_tag), 1);
        do_req(8'd7,   2'd2, 3, 1'b1, 52,  0, 2);
        chk("tag_after_op2", int'(done_tag), 0);
        do_req(8'd16,  2'd0, 2, 1'b1, 0,   1, 1);
        do_req(8'd255, 2'd1, 5, 1'b1, 2,   1, 1);
        do_req(8'd15,  2'd0, 9, 1'b1, 225, 0, 1);

        // One toggle during busy: second request follows the first.
        @(posedge clock);
        #2 data_in = 8'd5; op_in = 2'd3; tag_in = ~tag_in;
        wait_busy();
        @(posedge clock);
        #4 data_in = 8'd9; op_in = 2'd1; tag_in = ~tag_in;
        wait_done();
        chk("queued_result", int'(result), 12);
        chk("queued_ovf", int'(ovf), 0);

        // Two toggles during busy cancel.
        @(posedge clock);
        #2 data_in = 8'd6; op_in = 2'd3; tag_in = ~tag_in;
        wait_busy();
        @(posedge clock);
        #2 tag_in = ~tag_in;
        @(posedge clock);
        #2 tag_in = ~tag_in;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!busy) break;
        end
        repeat (8) @(negedge clock);
        chk("cancel_busy", int'(busy), 0);
        chk("cancel_tag_match", int'(done_tag), int'(tag_in));
        chk("cancel_result", int'(result), 241);
        chk("cancel_ovf", int'(ovf), 1);

        for (int n = 0; n < 40; n++) begin
            do_req(8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(1, 9),
                   1'b0, 0, 0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        repeat (3) @(negedge clock);
        chk("done_tag_edges", dut_edges, m_completions);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
